// File: rtl/fft_peak_ctrl.sv
// Ping-pong buffered peak finder over 16-bin FFT frames; reports the strongest bin per frame.
// Latency: out_valid 17 edges after a frame's last transfer; in_ready drops only while both banks are full.
module fft_peak_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic [3:0]  out_freq,
    output logic        busy
);

    localparam int NBIN = 16;
    localparam int DW   = 32;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CMP, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   bank_q [2][NBIN];
    logic [1:0]      full_q, full_d;
    logic            wb_q, wb_d;
    logic            rb_q, rb_d;
    logic [3:0]      wcnt_q, wcnt_d;
    logic [3:0]      idx_q, idx_d;
    logic [DW-1:0]   champ_q, champ_d;
    logic [3:0]      champ_f_q, champ_f_d;
    logic            out_valid_q, out_valid_d;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic [3:0]      out_freq_q, out_freq_d;

    logic            xfer;
    logic [DW-1:0]   chal;
    logic            chal_wins;

    // Exact power: each signed square is at most 2^30, so the 33-bit sum never wraps.
    function automatic logic [32:0] mag(input logic [31:0] x);
        logic signed [15:0] re;
        logic signed [15:0] im;
        logic signed [31:0] rr;
        logic signed [31:0] ii;
        re = x[31:16];
        im = x[15:0];
        rr = 32'(re) * 32'(re);
        ii = 32'(im) * 32'(im);
        return {1'b0, rr} + {1'b0, ii};
    endfunction

    assign in_ready  = !full_q[wb_q];
    assign xfer      = in_valid && in_ready;
    assign chal      = bank_q[rb_q][idx_q];
    assign chal_wins = mag(chal) > mag(champ_q);

    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_freq  = out_freq_q;

    always_ff @(posedge clk) begin
        if (xfer) begin
            bank_q[wb_q][wcnt_q] <= in_data;
        end
    end

    always_comb begin
        state_d     = state_q;
        full_d      = full_q;
        wb_d        = wb_q;
        rb_d        = rb_q;
        wcnt_d      = wcnt_q;
        idx_d       = idx_q;
        champ_d     = champ_q;
        champ_f_d   = champ_f_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_freq_d  = out_freq_q;

        if (xfer) begin
            wcnt_d = wcnt_q + 4'd1;
            if (wcnt_q == 4'd15) begin
                full_d[wb_q] = 1'b1;
                wb_d         = !wb_q;
            end
        end

        // Fill and engine always touch different banks, so both full updates may land together.
        case (state_q)
            S_IDLE: begin
                if (full_q[rb_q]) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                champ_d   = bank_q[rb_q][0];
                champ_f_d = 4'd0;
                idx_d     = 4'd1;
                state_d   = S_CMP;
            end
            S_CMP: begin
                if (chal_wins) begin
                    champ_d   = chal;
                    champ_f_d = idx_q;
                end
                idx_d = idx_q + 4'd1;
                if (idx_q == 4'd15) begin
                    out_data_d  = chal_wins ? chal : champ_q;
                    out_freq_d  = chal_wins ? idx_q : champ_f_q;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                full_d[rb_q] = 1'b0;
                rb_d         = !rb_q;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            full_q      <= 2'b00;
            wb_q        <= 1'b0;
            rb_q        <= 1'b0;
            wcnt_q      <= 4'd0;
            idx_q       <= 4'd0;
            champ_q     <= '0;
            champ_f_q   <= 4'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_freq_q  <= 4'd0;
        end else begin
            state_q     <= state_d;
            full_q      <= full_d;
            wb_q        <= wb_d;
            rb_q        <= rb_d;
            wcnt_q      <= wcnt_d;
            idx_q       <= idx_d;
            champ_q     <= champ_d;
            champ_f_q   <= champ_f_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_freq_q  <= out_freq_d;
        end
    end

endmodule

// File: tb/tb_fft_peak_ctrl.sv
// Randomized bench for fft_peak_ctrl: frames are driven through in_valid/in_ready and every winner
// is predicted by an argmax-of-power model over the transferred samples.
module tb_fft_peak_ctrl;

    typedef logic [31:0] frame_t [16];
    typedef struct {
        logic [31:0] d;
        logic [3:0]  f;
        int          c;
    } pulse_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic [3:0]  out_freq;
    logic        busy;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int hold_err = 0;
    bit busy_hist [8192];
    bit rdy_hist  [8192];
    pulse_t pq[$];
    int stall_q[$];
    logic        prev_ok = 1'b0;
    logic [31:0] prev_d = '0;
    logic [3:0]  prev_f = '0;

    fft_peak_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_freq  (out_freq),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Records output activity once per cycle, away from the active edge.
    always @(negedge clk) begin
        busy_hist[cyc & 8191] <= busy;
        rdy_hist[cyc & 8191]  <= in_ready;
        if (rst) begin
            if (out_valid) begin
                pq.push_back('{out_data, out_freq, cyc});
            end else if (prev_ok && (out_data !== prev_d || out_freq !== prev_f)) begin
                hold_err <= hold_err + 1;
            end
        end
        prev_ok <= rst;
        prev_d  <= out_data;
        prev_f  <= out_freq;
    end

    function automatic void ref_win(input frame_t f, output logic [31:0] d, output logic [3:0] k);
        longint best;
        longint re;
        longint im;
        longint m;
        best = -1;
        d = '0;
        k = '0;
        for (int i = 0; i < 16; i++) begin
            re = $signed(f[i][31:16]);
            im = $signed(f[i][15:0]);
            m  = re * re + im * im;
            if (m > best) begin
                best = m;
                d = f[i];
                k = 4'(i);
            end
        end
    endfunction

    function automatic frame_t rand_frame();
        frame_t f;
        for (int i = 0; i < 16; i++) f[i] = $urandom;
        return f;
    endfunction

    task automatic send_frame(input frame_t f, input int n, input int gap_pct, output int t_last);
        int i;
        int run;
        int budget;
        i = 0;
        run = 0;
        budget = 0;
        t_last = -1;
        while (i < n) begin
            @(negedge clk);
            budget++;
            if (budget > 2000) begin
                n_chk++;
                n_fail++;
                $display("FAIL send_timeout: sent %0d of %0d samples", i, n);
                in_valid = 1'b0;
                return;
            end
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
                in_data = $urandom;
                if (run > 0) stall_q.push_back(run);
                run = 0;
            end else begin
                in_valid = 1'b1;
                in_data = f[i];
                if (in_ready) begin
                    if (run > 0) stall_q.push_back(run);
                    run = 0;
                    if (i == n - 1) t_last = cyc + 1;
                    i++;
                end else begin
                    run++;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        in_valid = 1'b0;
        in_data = $urandom;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_pulses(input int n, input int budget);
        int b;
        b = 0;
        while (pq.size() < n && b < budget) begin
            @(negedge clk);
            b++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_chk++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        n_chk++; if (out_freq !== 4'h0) begin n_fail++; $display("FAIL reset_out_freq: got %h want 0", out_freq); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_frame();
        frame_t f;
        int t;
        for (int k = 0; k < 16; k++) f[k] = {16'(k), 16'(k)};
        f[5] = 32'h01000100;
        pq.delete();
        send_frame(f, 16, 0, t);
        idle(1);
        wait_pulses(1, 60);
        repeat (25) @(negedge clk);
        n_chk++; if (pq.size() !== 1) begin n_fail++; $display("FAIL single_pulse_count: got %0d want 1", pq.size()); end
        if (pq.size() >= 1) begin
            n_chk++; if (pq[0].f !== 4'd5) begin n_fail++; $display("FAIL single_freq: got %0d want 5", pq[0].f); end
            n_chk++; if (pq[0].d !== 32'h01000100) begin n_fail++; $display("FAIL single_data: got %h want 01000100", pq[0].d); end
            n_chk++; if (pq[0].c !== t + 17) begin n_fail++; $display("FAIL single_latency: pulse at %0d want %0d", pq[0].c, t + 17); end
        end
        n_chk++; if (busy_hist[t & 8191] !== 1'b0) begin n_fail++; $display("FAIL busy_before_e1: got 1 want 0"); end
        n_chk++; if (busy_hist[(t + 1) & 8191] !== 1'b1) begin n_fail++; $display("FAIL busy_after_e1: got 0 want 1"); end
        n_chk++; if (busy_hist[(t + 17) & 8191] !== 1'b1) begin n_fail++; $display("FAIL busy_in_done: got 0 want 1"); end
        n_chk++; if (busy_hist[(t + 18) & 8191] !== 1'b0) begin n_fail++; $display("FAIL busy_after_e18: got 1 want 0"); end
    endtask

    task automatic test_tie();
        frame_t f1;
        frame_t f2;
        int t;
        for (int k = 0; k < 16; k++) begin f1[k] = '0; f2[k] = '0; end
        f1[3] = 32'h00030004;
        f1[9] = 32'h00030004;
        pq.delete();
        send_frame(f1, 16, 0, t);
        send_frame(f2, 16, 0, t);
        idle(1);
        wait_pulses(2, 100);
        n_chk++; if (pq.size() !== 2) begin n_fail++; $display("FAIL tie_pulse_count: got %0d want 2", pq.size()); end
        if (pq.size() >= 2) begin
            n_chk++; if (pq[0].f !== 4'd3) begin n_fail++; $display("FAIL tie_freq: got %0d want 3", pq[0].f); end
            n_chk++; if (pq[0].d !== 32'h00030004) begin n_fail++; $display("FAIL tie_data: got %h want 00030004", pq[0].d); end
            n_chk++; if (pq[1].f !== 4'd0) begin n_fail++; $display("FAIL zero_freq: got %0d want 0", pq[1].f); end
            n_chk++; if (pq[1].d !== 32'h0) begin n_fail++; $display("FAIL zero_data: got %h want 0", pq[1].d); end
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_extremes();
        frame_t f [3];
        logic [31:0] ed;
        logic [3:0]  ef;
        int t;
        for (int j = 0; j < 3; j++) for (int k = 0; k < 16; k++) f[j][k] = '0;
        f[0][15] = 32'h00008000;
        f[0][2]  = 32'h7FFF7FFF;
        f[1][15] = 32'h00008000;
        f[2][2]  = 32'h7FFF7FFF;
        f[2][7]  = 32'h80008000;
        pq.delete();
        for (int j = 0; j < 3; j++) begin
            send_frame(f[j], 16, 0, t);
            idle(30);
        end
        wait_pulses(3, 60);
        n_chk++; if (pq.size() !== 3) begin n_fail++; $display("FAIL ext_pulse_count: got %0d want 3", pq.size()); end
        n_chk++; if (pq.size() >= 1 && pq[0].f !== 4'd2) begin n_fail++; $display("FAIL ext_bin2_freq: got %0d want 2", pq[0].f); end
        n_chk++; if (pq.size() >= 2 && pq[1].f !== 4'd15) begin n_fail++; $display("FAIL ext_bin15_freq: got %0d want 15", pq[1].f); end
        n_chk++; if (pq.size() >= 2 && pq[1].d !== 32'h00008000) begin n_fail++; $display("FAIL ext_bin15_data: got %h want 00008000", pq[1].d); end
        for (int j = 0; j < 3 && j < pq.size(); j++) begin
            ref_win(f[j], ed, ef);
            n_chk++;
            if (pq[j].f !== ef || pq[j].d !== ed) begin
                n_fail++;
                $display("FAIL ext_model_%0d: got %0d/%h want %0d/%h", j, pq[j].f, pq[j].d, ef, ed);
            end
        end
    endtask

    task automatic test_back_to_back();
        frame_t f [3];
        int t [3];
        logic [31:0] ed;
        logic [3:0]  ef;
        for (int j = 0; j < 3; j++) f[j] = rand_frame();
        pq.delete();
        stall_q.delete();
        for (int j = 0; j < 3; j++) send_frame(f[j], 16, 0, t[j]);
        idle(1);
        wait_pulses(3, 120);
        repeat (20) @(negedge clk);
        n_chk++; if (t[1] !== t[0] + 16) begin n_fail++; $display("FAIL b2b_frame2_end: got %0d want %0d", t[1], t[0] + 16); end
        n_chk++; if (t[2] !== t[1] + 18) begin n_fail++; $display("FAIL b2b_frame3_end: got %0d want %0d", t[2], t[1] + 18); end
        n_chk++; if (stall_q.size() !== 1) begin n_fail++; $display("FAIL b2b_stall_runs: got %0d want 1", stall_q.size()); end
        n_chk++; if (stall_q.size() >= 1 && stall_q[0] !== 2) begin n_fail++; $display("FAIL b2b_stall_len: got %0d want 2", stall_q[0]); end
        n_chk++; if (rdy_hist[(t[1] + 2) & 8191] !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_back: got 0 want 1"); end
        n_chk++; if (pq.size() !== 3) begin n_fail++; $display("FAIL b2b_pulse_count: got %0d want 3", pq.size()); end
        for (int j = 0; j < 3 && j < pq.size(); j++) begin
            ref_win(f[j], ed, ef);
            n_chk++;
            if (pq[j].f !== ef || pq[j].d !== ed) begin
                n_fail++;
                $display("FAIL b2b_winner_%0d: got %0d/%h want %0d/%h", j, pq[j].f, pq[j].d, ef, ed);
            end
            n_chk++;
            if (pq[j].c !== t[0] + 17 + 18 * j) begin
                n_fail++;
                $display("FAIL b2b_pulse_time_%0d: got %0d want %0d", j, pq[j].c, t[0] + 17 + 18 * j);
            end
        end
    endtask

    task automatic test_bursty();
        frame_t f [4];
        int t;
        int h0;
        logic [31:0] ed;
        logic [3:0]  ef;
        h0 = hold_err;
        pq.delete();
        for (int j = 0; j < 4; j++) begin
            f[j] = rand_frame();
            send_frame(f[j], 16, 40, t);
        end
        idle(1);
        wait_pulses(4, 200);
        repeat (10) @(negedge clk);
        n_chk++; if (pq.size() !== 4) begin n_fail++; $display("FAIL burst_pulse_count: got %0d want 4", pq.size()); end
        for (int j = 0; j < 4 && j < pq.size(); j++) begin
            ref_win(f[j], ed, ef);
            n_chk++;
            if (pq[j].f !== ef || pq[j].d !== ed) begin
                n_fail++;
                $display("FAIL burst_winner_%0d: got %0d/%h want %0d/%h", j, pq[j].f, pq[j].d, ef, ed);
            end
            if (j > 0) begin
                n_chk++;
                if (pq[j].c - pq[j - 1].c < 18) begin
                    n_fail++;
                    $display("FAIL burst_spacing_%0d: got %0d want >=18", j, pq[j].c - pq[j - 1].c);
                end
            end
        end
        n_chk++; if (hold_err !== h0) begin n_fail++; $display("FAIL burst_hold: got %0d changes want 0", hold_err - h0); end
    endtask

    task automatic test_reset_mid();
        frame_t fa;
        frame_t fb;
        int t;
        int b;
        logic [31:0] ed;
        logic [3:0]  ef;
        fa = rand_frame();
        pq.delete();
        send_frame(fa, 16, 0, t);
        idle(1);
        b = 0;
        while (cyc < t + 8 && b < 50) begin @(negedge clk); b++; end
        #2 rst = 1'b0;
        #1;
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midcmp_out_valid: got %b want 0", out_valid); end
        n_chk++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL midcmp_out_data: got %h want 0", out_data); end
        n_chk++; if (out_freq !== 4'h0) begin n_fail++; $display("FAIL midcmp_out_freq: got %h want 0", out_freq); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midcmp_busy: got %b want 0", busy); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        n_chk++; if (pq.size() !== 0) begin n_fail++; $display("FAIL midcmp_no_pulse: got %0d pulses want 0", pq.size()); end

        for (int k = 0; k < 16; k++) fa[k] = $urandom & 32'h0FFF0FFF;
        send_frame(fa, 7, 0, t);
        idle(0);
        #2 rst = 1'b0;
        #1;
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midfill_in_ready: got %b want 1", in_ready); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midfill_busy: got %b want 0", busy); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        fb = rand_frame();
        for (int k = 1; k < 16; k++) fb[k] = fb[k] & 32'h0FFF0FFF;
        fb[0] = 32'h7FFF7FFF;
        pq.delete();
        send_frame(fb, 16, 0, t);
        idle(1);
        wait_pulses(1, 60);
        repeat (20) @(negedge clk);
        ref_win(fb, ed, ef);
        n_chk++; if (pq.size() !== 1) begin n_fail++; $display("FAIL post_reset_pulses: got %0d want 1", pq.size()); end
        n_chk++;
        if (pq.size() < 1 || pq[0].f !== ef || pq[0].d !== ed) begin
            n_fail++;
            $display("FAIL post_reset_winner: got %0d/%h want %0d/%h",
                     pq.size() > 0 ? pq[0].f : 4'hx, pq.size() > 0 ? pq[0].d : 32'hx, ef, ed);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_tie();
        test_extremes();
        test_back_to_back();
        test_bursty();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
